adder_pipe_nbit: RTL and testbench
==================================

# adder_pipe_nbit

Parametrised, pipelined successor to the 4-bit combinational adder. Adds two WIDTH-bit unsigned operands plus carry-in, splitting the carry chain into STAGES registered chunks so wide adds close timing. Valid/ready handshakes on both sides allow a free-running producer and a stalling consumer. Sits between operand sources and any result sink in the datapath; one result per cycle when unstalled.

## Interface
- WIDTH, 16, operand/sum width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth; each stage adds one WIDTH/STAGES-bit chunk; 1 ≤ STAGES ≤ WIDTH.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in to bit 0.
- in_valid  input  1  A/B/Cin valid.
- in_ready  output  1  block can accept this cycle.
- Sum  output  WIDTH  result (A + B + Cin) mod 2^WIDTH.
- Cout  output  1  carry out of MSB.
- out_valid  output  1  Sum/Cout valid.
- out_ready  input  1  sink accepts this cycle.

## Operation
- Chunk width C = WIDTH/STAGES. Stage s (1..STAGES) adds chunk s-1 of A and B plus the carry registered by stage s-1 (stage 1 uses Cin).
- Operand chunks not yet consumed travel through skew registers; completed sum chunks travel through de-skew registers so all WIDTH bits of Sum emerge together from the last stage.
- Each stage holds a valid bit; no other state machine.
- Global advance enable: en = !out_valid || out_ready. in_ready = en (combinational).
- When en = 1 every stage register loads from its predecessor; stage 1 loads the input word and valid bit in_valid.
- When en = 0 all stage registers, including data and valid bits, hold.
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready at a rising edge.
- Bubbles (invalid stages) are not compressed while stalled; they drain only when en = 1.
- Data is never dropped or duplicated; order is preserved.
- Arithmetic is unsigned; {Cout, Sum} = A + B + Cin exactly, WIDTH+1 bits.

## Timing
- Reset (rst_n low, asynchronous): all valid bits 0, out_valid = 0, Sum = 0, Cout = 0, all data/carry registers 0; in_ready = 1 during and after reset.
- Latency: a word accepted at edge t presents on Sum/Cout with out_valid = 1 from edge t+STAGES-1 onward, i.e. STAGES cycles, if unstalled.
- Throughput: one word per cycle while out_ready = 1.
- out_valid high with out_ready low: Sum/Cout/out_valid must stay stable until transferred; in_ready is 0 that cycle.
- Simultaneous transfer in and out in the same cycle is legal and required for full throughput.
- in_valid low while en = 1: a bubble enters stage 1.
- Reset asserted mid-operation: all in-flight words discarded immediately; no output transfer occurs after reset assertion until new words are accepted.
- STAGES = 1: single registered ripple adder, latency 1.

## Configuration
- ADDER_PIPE_SAT_EN defined: unsigned saturation. When the full result overflows (Cout = 1), Sum is forced to all-ones at the last stage. Cout still reports 1 so the sink sees the overflow.
- ADDER_PIPE_SAT_EN undefined: Sum wraps modulo 2^WIDTH. Cout = carry. No saturation logic is instantiated.
- Latency and handshake are identical in both builds.

## Test plan
- Full-chain carry (WIDTH=16, STAGES=4): A=0xFFFF, B=0x0001, Cin=0, out_ready=1 → after 4 cycles Sum=0x0000, Cout=1. With ADDER_PIPE_SAT_EN: Sum=0xFFFF, Cout=1.
- Cin-only propagation: A=0x0FFF, B=0x0000, Cin=1 → Sum=0x1000, Cout=0, 4 cycles later.
- Streaming: 100 back-to-back random triples, out_ready=1 → 100 results in order, one per cycle, each matching A+B+Cin; in_ready never low.
- Backpressure: stream 8 words, out_ready=0 for cycles 6–10 → in_ready=0 and Sum/Cout/out_valid frozen while stalled; all 8 results delivered once, in order.
- Reset mid-flight: accept 3 words, assert rst_n=0 for 2 cycles at cycle 2 → out_valid=0, Sum=0, Cout=0 immediately; no stale result after release.
- Parameter sweep: (WIDTH, STAGES) = (4,1), (8,2), (32,8); random stimulus checked against WIDTH+1-bit reference sum, latency = STAGES.

Source files
------------

// File: rtl/adder_pipe_nbit_if.sv
// Handshake bundle for adder_pipe_nbit: operands and carry-in with
// in_valid/in_ready on the producer side, and the sum and carry-out with
// out_valid/out_ready on the consumer side.
// The adder uses the slave modport; an operand source or result sink
// uses the master modport.
interface adder_pipe_nbit_if #(
   parameter int WIDTH = 16
) ();
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] Sum;
   logic             Cout;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output A, B, Cin, in_valid, out_ready,
      input  in_ready, Sum, Cout, out_valid
   );

   modport slave (
      input  A, B, Cin, in_valid, out_ready,
      output in_ready, Sum, Cout, out_valid
   );
endinterface

// File: rtl/adder_pipe_nbit.sv
// adder_pipe_nbit: pipelined WIDTH-bit unsigned adder with carry-in.
// The carry chain is cut into STAGES chunks of WIDTH/STAGES bits, one
// chunk per registered stage. Each stage carries the whole operand words
// (skew) and the partially built sum (de-skew), so all sum bits leave the
// last stage together. A single advance enable moves or freezes the whole
// pipe: en = !out_valid || out_ready, and in_ready = en.
// Optional build macro ADDER_PIPE_SAT_EN: on overflow the last stage forces
// Sum to all-ones, while Cout still reports the overflow.
module adder_pipe_nbit #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   adder_pipe_nbit_if.slave   bus
);
   localparam int CHUNK = WIDTH / STAGES;

   // One chunk of ripple addition; the MSB of the result is the chunk carry.
   function automatic logic [CHUNK:0] chunk_add(
      input logic [CHUNK-1:0] a,
      input logic [CHUNK-1:0] b,
      input logic             ci
   );
      return {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
   endfunction

   // Stage registers. Index s holds the state after stage s+1 has added
   // chunk s. Operand words travel whole, and later stages read their own
   // chunk from them.
   logic [WIDTH-1:0] a_r     [STAGES];
   logic [WIDTH-1:0] b_r     [STAGES];
   logic [WIDTH-1:0] sum_r   [STAGES];
   logic             carry_r [STAGES];
   logic             valid_r [STAGES];

   logic [WIDTH-1:0] a_nxt_s     [STAGES];
   logic [WIDTH-1:0] b_nxt_s     [STAGES];
   logic [WIDTH-1:0] sum_nxt_s   [STAGES];
   logic             carry_nxt_s [STAGES];
   logic             valid_nxt_s [STAGES];
   logic [CHUNK:0]   part_s      [STAGES];

   logic [WIDTH-1:0] last_sum_s;
   logic             en_s;

   // The pipe moves only when the output register is empty or is being drained.
   assign en_s         = !valid_r[STAGES-1] || bus.out_ready;
   assign bus.in_ready = en_s;
   assign bus.Sum       = sum_r[STAGES-1];
   assign bus.Cout      = carry_r[STAGES-1];
   assign bus.out_valid = valid_r[STAGES-1];

   // Next-state of every stage: add this stage's chunk, shift everything else along.
   always_comb begin
      for (int s = 0; s < STAGES; s++) begin
         a_nxt_s[s]     = {WIDTH{1'b0}};
         b_nxt_s[s]     = {WIDTH{1'b0}};
         sum_nxt_s[s]   = {WIDTH{1'b0}};
         carry_nxt_s[s] = 1'b0;
         valid_nxt_s[s] = 1'b0;
         part_s[s]      = {(CHUNK+1){1'b0}};
      end

      // Stage 1 takes the incoming word and Cin directly.
      part_s[0]                 = chunk_add(bus.A[CHUNK-1:0], bus.B[CHUNK-1:0], bus.Cin);
      a_nxt_s[0]                = bus.A;
      b_nxt_s[0]                = bus.B;
      sum_nxt_s[0][CHUNK-1:0]   = part_s[0][CHUNK-1:0];
      carry_nxt_s[0]            = part_s[0][CHUNK];
      valid_nxt_s[0]            = bus.in_valid;

      // Later stages take the previous stage's operands, partial sum and carry.
      for (int s = 1; s < STAGES; s++) begin
         part_s[s]      = chunk_add(a_r[s-1][s*CHUNK +: CHUNK],
                                    b_r[s-1][s*CHUNK +: CHUNK],
                                    carry_r[s-1]);
         a_nxt_s[s]     = a_r[s-1];
         b_nxt_s[s]     = b_r[s-1];
         sum_nxt_s[s]   = sum_r[s-1];
         sum_nxt_s[s][s*CHUNK +: CHUNK] = part_s[s][CHUNK-1:0];
         carry_nxt_s[s] = part_s[s][CHUNK];
         valid_nxt_s[s] = valid_r[s-1];
      end
   end

`ifdef ADDER_PIPE_SAT_EN
   // On overflow, clamp the finished sum to all-ones before it enters the output register.
   assign last_sum_s = carry_nxt_s[STAGES-1] ? {WIDTH{1'b1}} : sum_nxt_s[STAGES-1];
`else
   // Wrapping build: the finished sum passes straight into the output register.
   assign last_sum_s = sum_nxt_s[STAGES-1];
`endif

   // Stage registers: clear on reset, advance all together on en, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < STAGES; s++) begin
            a_r[s]     <= {WIDTH{1'b0}};
            b_r[s]     <= {WIDTH{1'b0}};
            sum_r[s]   <= {WIDTH{1'b0}};
            carry_r[s] <= 1'b0;
            valid_r[s] <= 1'b0;
         end
      end else if (en_s) begin
         for (int s = 0; s < STAGES; s++) begin
            a_r[s]     <= a_nxt_s[s];
            b_r[s]     <= b_nxt_s[s];
            sum_r[s]   <= sum_nxt_s[s];
            carry_r[s] <= carry_nxt_s[s];
            valid_r[s] <= valid_nxt_s[s];
         end
         sum_r[STAGES-1] <= last_sum_s;
      end
   end
endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Testbench for adder_pipe_nbit (main instance WIDTH=16, STAGES=4, plus
// three instances with other WIDTH/STAGES settings checked against random operands).
module tb_adder_pipe_nbit;
   localparam int W = 16;
   localparam int S = 4;
`ifdef ADDER_PIPE_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic sw_rst_n = 1'b1;
   always #5 clk = ~clk;

   adder_pipe_nbit_if #(.WIDTH(W)) bus ();
   adder_pipe_nbit #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int total = 0;
   int bad = 0;
   int out_cnt = 0;
   int sweep_done = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct packed { logic [W-1:0] sum; logic cout; } res_t;

   function automatic res_t ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
      logic [W:0] f;
      res_t r;
      f = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      r.cout = f[W];
      r.sum  = (SAT && f[W]) ? {W{1'b1}} : f[W-1:0];
      return r;
   endfunction

   // Scoreboard monitor: at negedge, predict this cycle's transfers on the coming edge.
   res_t exp_q [$];
   logic stall_prev = 1'b0;
   logic [W+1:0] held = '0;
   always @(negedge clk) begin
      res_t e;
      if (!rst_n) begin
         exp_q.delete();
         stall_prev = 1'b0;
      end else begin
         if (stall_prev)
            chk("stall_hold", {bus.out_valid, bus.Cout, bus.Sum}, held);
         if (bus.out_valid && !bus.out_ready)
            chk("stall_in_ready", bus.in_ready, 1'b0);
         if (bus.out_valid && bus.out_ready) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
               chk("unexpected_out", 1'b1, 1'b0);
            end else begin
               e = exp_q.pop_front();
               chk("order_sum", bus.Sum, e.sum);
               chk("order_cout", bus.Cout, e.cout);
            end
         end
         if (bus.in_valid && bus.in_ready)
            exp_q.push_back(ref_add(bus.A, bus.B, bus.Cin));
         stall_prev = bus.out_valid && !bus.out_ready;
         held = {bus.out_valid, bus.Cout, bus.Sum};
      end
   end

   // Width/depth sweep instances with their own reset.
   localparam int SW_W [3] = '{4, 8, 32};
   localparam int SW_S [3] = '{1, 2, 8};
   for (genvar g = 0; g < 3; g++) begin : g_sweep
      localparam int GW = SW_W[g];
      localparam int GS = SW_S[g];
      adder_pipe_nbit_if #(.WIDTH(GW)) sbus ();
      adder_pipe_nbit #(.WIDTH(GW), .STAGES(GS)) sdut (.clk(clk), .rst_n(sw_rst_n), .bus(sbus));
      logic [GW:0] sexp_q [$];
      int          scyc_q [$];
      initial begin
         logic [GW:0] r;
         logic [GW:0] e;
         int c0;
         sbus.A = {GW{1'b0}};
         sbus.B = {GW{1'b0}};
         sbus.Cin = 1'b0;
         sbus.in_valid = 1'b0;
         sbus.out_ready = 1'b1;
         wait (sw_rst_n === 1'b0);
         wait (sw_rst_n === 1'b1);
         @(posedge clk); #1;
         for (int cyc = 0; cyc < 40; cyc++) begin
            sbus.in_valid = (cyc < 30);
            sbus.A = GW'($urandom);
            sbus.B = GW'($urandom);
            sbus.Cin = 1'($urandom);
            @(negedge clk);
            chk($sformatf("sweep%0d_in_ready", GW), sbus.in_ready, 1'b1);
            if (sbus.out_valid) begin
               if (sexp_q.size() == 0) begin
                  chk($sformatf("sweep%0d_extra", GW), 1'b1, 1'b0);
               end else begin
                  e = sexp_q.pop_front();
                  c0 = scyc_q.pop_front();
                  chk($sformatf("sweep%0d_result", GW), {sbus.Cout, sbus.Sum}, e);
                  chk($sformatf("sweep%0d_latency", GW), cyc, c0 + GS);
               end
            end
            if (sbus.in_valid && sbus.in_ready) begin
               r = {1'b0, sbus.A} + {1'b0, sbus.B} + {{GW{1'b0}}, sbus.Cin};
               if (SAT && r[GW]) r[GW-1:0] = {GW{1'b1}};
               sexp_q.push_back(r);
               scyc_q.push_back(cyc);
            end
            @(posedge clk); #1;
         end
         chk($sformatf("sweep%0d_drained", GW), sexp_q.size(), 0);
         sweep_done++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] sum;
      logic         cout;
   } vec_t;
   vec_t vecs [10];

   initial begin
      int base;
      int sent;
      logic acc;
      vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, (SAT ? 16'hFFFF : 16'h0000), 1'b1};
      vecs[1] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0};
      vecs[2] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
      vecs[3] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
      vecs[4] = '{16'h8000, 16'h8000, 1'b1, (SAT ? 16'hFFFF : 16'h0001), 1'b1};
      vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
      vecs[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
      vecs[7] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};
      vecs[8] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};
      vecs[9] = '{16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0};

      bus.A = 16'h0000; bus.B = 16'h0000; bus.Cin = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      #1;
      rst_n = 1'b0;
      sw_rst_n = 1'b0;
      #1;
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_sum", bus.Sum, 16'h0000);
      chk("rst_cout", bus.Cout, 1'b0);
      chk("rst_in_ready", bus.in_ready, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      sw_rst_n = 1'b1;
      chk("post_rst_in_ready", bus.in_ready, 1'b1);
      chk("post_rst_out_valid", bus.out_valid, 1'b0);

      // Directed vectors, one at a time, with exact latency.
      for (int i = 0; i < 10; i++) begin
         bus.A = vecs[i].a; bus.B = vecs[i].b; bus.Cin = vecs[i].cin;
         bus.in_valid = 1'b1;
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         repeat (S - 2) @(posedge clk);
         #1;
         chk($sformatf("vec%0d_early_valid", i), bus.out_valid, 1'b0);
         @(posedge clk); #1;
         chk($sformatf("vec%0d_valid", i), bus.out_valid, 1'b1);
         chk($sformatf("vec%0d_sum", i), bus.Sum, vecs[i].sum);
         chk($sformatf("vec%0d_cout", i), bus.Cout, vecs[i].cout);
         @(posedge clk); #1;
         chk($sformatf("vec%0d_drained", i), bus.out_valid, 1'b0);
      end

      // Back-to-back streaming of 100 random words.
      base = out_cnt;
      for (int i = 0; i < 100; i++) begin
         bus.A = 16'($urandom); bus.B = 16'($urandom); bus.Cin = 1'($urandom);
         bus.in_valid = 1'b1;
         #1;
         chk("stream_in_ready", bus.in_ready, 1'b1);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      repeat (S - 1) @(posedge clk);
      @(negedge clk); #1;
      chk("stream_count", out_cnt - base, 100);
      @(posedge clk); #1;
      chk("stream_queue_empty", exp_q.size(), 0);

      // Backpressure: out_ready low for cycles 6..10.
      base = out_cnt;
      sent = 0;
      for (int c = 0; c < 30; c++) begin
         bus.out_ready = !(c >= 6 && c <= 10);
         bus.in_valid = (sent < 8);
         bus.A = 16'hFFF0 + 16'(sent);
         bus.B = 16'h0008 + 16'(sent * 3);
         bus.Cin = sent[0];
         #1;
         if (!bus.out_ready && bus.out_valid)
            chk("bp_in_ready", bus.in_ready, 1'b0);
         acc = bus.in_valid && bus.in_ready;
         @(posedge clk); #1;
         if (acc) sent++;
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      chk("bp_sent", sent, 8);
      chk("bp_count", out_cnt - base, 8);
      chk("bp_queue_empty", exp_q.size(), 0);

      // Reset in the middle of traffic.
      for (int i = 0; i < 3; i++) begin
         bus.A = 16'h1234 + 16'(i); bus.B = 16'h0101; bus.Cin = 1'b1;
         bus.in_valid = 1'b1;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("pre_rst_valid", bus.out_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", bus.out_valid, 1'b0);
      chk("mid_rst_sum", bus.Sum, 16'h0000);
      chk("mid_rst_cout", bus.Cout, 1'b0);
      chk("mid_rst_in_ready", bus.in_ready, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < S + 2; i++) begin
         @(posedge clk); #1;
         chk("post_rst_idle", bus.out_valid, 1'b0);
      end
      base = out_cnt;
      bus.A = 16'h00FF; bus.B = 16'h0F01; bus.Cin = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (S - 1) @(posedge clk);
      #1;
      chk("post_rst_sum", bus.Sum, 16'h1000);
      chk("post_rst_valid", bus.out_valid, 1'b1);
      @(posedge clk); #1;
      chk("post_rst_count", out_cnt - base, 1);

      chk("sweep_done", sweep_done, 3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
